// File: rtl/in_to_fifo_pkg.sv
// in_to_fifo_pkg: state codes and defaults shared
// between the ingress and egress byte FSMs.
package in_to_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IN    = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_WRITE_WAIT = 3'd3,
    ST_WRITE      = 3'd4
  } state_e;

  localparam logic [7:0] EOM_BYTE_DEF = 8'h0D;
  localparam int         TIMEOUT_DEF  = 1000;
  localparam int         CNT_W_DEF    = 16;

endpackage

// File: rtl/in_to_fifo_sat_counter.sv
// in_to_fifo_sat_counter: saturating up-counter,
// synchronous clear has priority over increment.
module in_to_fifo_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/in_to_fifo.sv
// in_to_fifo: takes producer bytes over valid/ack and
// writes them to the byte FIFO, dropping after a stall.
module in_to_fifo
  import in_to_fifo_pkg::*;
#(
  parameter int         TIMEOUT  = TIMEOUT_DEF,
  parameter logic [7:0] EOM_BYTE = EOM_BYTE_DEF,
  parameter int         CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ack,
  input  logic             fifo_full,
  input  logic             fifo_busy,
  output logic             fifo_we,
  output logic [7:0]       fifo_wdata,
  output logic             idle,
  output logic             msg_done,
  output logic             overflow,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [2:0]       state
);

  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    hold_q, hold_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          done_q, done_d;
  logic          idle_q, idle_d;
  logic          ovf_q, ovf_d;
  logic          inc_byte, inc_drop;
  logic          stalled;

  assign stalled = fifo_full | fifo_busy;

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    stall_d  = stall_q;
    done_d   = 1'b0;
    inc_byte = 1'b0;
    inc_drop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          hold_d  = in_data;
          ack_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!in_valid) begin
          ack_d   = 1'b0;
          stall_d = '0;
          state_d = ST_WRITE_WAIT;
        end
      end
      ST_WRITE_WAIT: begin
        if (!stalled) begin
          we_d    = 1'b1;
          wdata_d = hold_q;
          done_d  = (hold_q == EOM_BYTE);
          state_d = ST_WRITE;
        end else if ((TIMEOUT != 0) && (stall_q == STALL_MAX)) begin
          inc_drop = 1'b1;
          state_d  = enable ? ST_WAIT_IN : ST_IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      ST_WRITE: begin
        inc_byte = 1'b1;
        state_d  = enable ? ST_WAIT_IN : ST_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    idle_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_IN);
    ovf_d  = clear ? 1'b0 : (ovf_q | inc_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hold_q  <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
    end
  end

  in_to_fifo_sat_counter #(.W(CNT_W)) u_byte_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear),
    .inc_i (inc_byte),
    .cnt_o (byte_count)
  );

  in_to_fifo_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear),
    .inc_i (inc_drop),
    .cnt_o (drop_count)
  );

  assign in_ack     = ack_q;
  assign fifo_we    = we_q;
  assign fifo_wdata = wdata_q;
  assign idle       = idle_q;
  assign msg_done   = done_q;
  assign overflow   = ovf_q;
  assign state      = state_q;

endmodule

// File: doc/in_to_fifo.md
Name: in_to_fifo

Overview:
Ingress counterpart of the FIFO-to-output path. It accepts bytes from an input producer (keypad/serial receiver) over a valid/ack handshake and writes each byte into the shared byte FIFO with a single-cycle write strobe. It waits out FIFO full/busy stalls, and drops a byte only after a configurable timeout. It also keeps byte/drop statistics and flags end-of-message bytes for the downstream controller.

Parameters:
TIMEOUT, 1000, cycles a held byte may stall on fifo_full/fifo_busy before it is dropped; 0 = never drop
EOM_BYTE, 8'h0D, byte value that marks end of message
CNT_W, 16, width of byte_count and drop_count

Ports:
clk  in  1  system clock; all state updates on posedge clk
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  block runs while high
clear  in  1  synchronous clear of counters and overflow
in_valid  in  1  producer has a byte on in_data; held high until in_ack seen
in_data  in  8  producer byte
in_ack  out  1  byte captured; held until in_valid drops
fifo_full  in  1  FIFO cannot accept a write
fifo_busy  in  1  FIFO port busy this cycle
fifo_we  out  1  FIFO write strobe, one cycle per byte
fifo_wdata  out  8  byte to write; valid while fifo_we=1
idle  out  1  high in IDLE and WAIT_IN (no byte in flight)
msg_done  out  1  one-cycle pulse when EOM_BYTE is written
overflow  out  1  sticky: at least one byte dropped
byte_count  out  CNT_W  bytes written to FIFO, saturating
drop_count  out  CNT_W  bytes dropped, saturating
state  out  3  current state code, for debug

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ack=0, fifo_we=0, fifo_wdata=0, idle=1, msg_done=0, overflow=0, both counts=0, internal hold register and stall counter=0.
- All outputs are registered.
- States (code): IDLE(0), WAIT_IN(1), RELEASE(2), WRITE_WAIT(3), WRITE(4). Codes 5-7 are illegal and go to IDLE next cycle.
- IDLE: if enable, go to WAIT_IN.
- WAIT_IN: if !enable, go to IDLE. Else if in_valid: hold<=in_data, in_ack<=1, go to RELEASE.
- RELEASE: in_ack stays 1 until in_valid=0. Then in_ack<=0, stall counter<=0, go to WRITE_WAIT.
- WRITE_WAIT:
  - If !fifo_full && !fifo_busy: fifo_we<=1, fifo_wdata<=hold, go to WRITE.
  - Else if TIMEOUT!=0 and stall counter==TIMEOUT-1: drop the byte, drop_count++, overflow<=1, go to WAIT_IN (IDLE if !enable).
  - Else stall counter++.
- WRITE: fifo_we<=0, byte_count++. If hold==EOM_BYTE, msg_done=1 for exactly this cycle. Go to WAIT_IN, or IDLE if !enable.
- Latency: in_valid rises at cycle N (FIFO free, in_valid drops at first ack), so in_ack=1 at N+1 and fifo_we=1 at N+3.
- Minimum rate: one byte per 4 cycles.
- enable low mid-byte (RELEASE/WRITE_WAIT/WRITE): the current byte completes, is written or dropped, and the block then returns to IDLE. in_valid is never acked while enable=0.
- fifo_busy and fifo_full are sampled only in WRITE_WAIT. fifo_we is never asserted while either is high in the same cycle.
- Counters saturate at all-ones; no wrap.
- clear=1: counts and overflow <=0. If clear coincides with an increment or drop, clear wins. The FSM is unaffected.
- Reset mid-operation: the held byte is discarded, with no write and no drop counted.

Decomposition:
- Shared package: state encoding constants (IDLE..WRITE) and default EOM_BYTE, so they are consistent with the egress FSM.
- One natural sub-module: sat_counter (CNT_W, inc, clr; clear priority). Instantiate it twice, for byte_count and drop_count.

Test Plan:
- Single byte, FIFO free: in_data=8'h41, in_valid pulsed until ack -> in_ack 1 cycle later; fifo_we=1 exactly once with fifo_wdata=8'h41; byte_count=1; idle returns 1.
- Stall then go: fifo_full=1 for 20 cycles, TIMEOUT=1000, byte 8'h55 -> no fifo_we while full; write on the first free cycle; drop_count=0.
- Timeout drop: TIMEOUT=8, fifo_busy held high, byte 8'h7E -> no fifo_we; after 8 WRITE_WAIT cycles drop_count=1, overflow=1; next byte 8'h31 written after busy clears.
- EOM: bytes 8'h48, 8'h69, 8'h0D -> three writes; msg_done pulses once, coincident with the WRITE following the 8'h0D strobe; byte_count=3.
- Enable/reset mid-op: enable drops in RELEASE -> byte still written, then state=0, and in_valid is not acked. rst_n=0 in WRITE_WAIT -> all outputs return to reset values immediately.
- Saturation/clear: CNT_W=4, 17 bytes -> byte_count=4'hF. Assert clear on the same cycle as an increment -> count=0.
